jstk_spi_responder: RTL and testbench

JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

---
 rtl/jstk_spi_responder.sv | 184 ++++++++++++++++++
 tb/tb_jstk_spi_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
// Joystick-style SPI responder (mode 0).
// Each frame reports the X and Y positions and the two buttons to the initiator.
// When the command byte matches, the frame also loads a 24-bit RGB value.
// All SPI pins are asynchronous: they pass through 2-flop synchronizers and
// are edge-detected in the clk_i domain.
module jstk_spi_responder #(
    parameter logic [7:0]  cmd_led_p    = 8'h84,
    parameter int unsigned frame_bits_p = 40
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        spi_cs_i,
    input  logic        spi_sck_i,
    input  logic        spi_sd_i,
    output logic        spi_sd_o,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic        trigger_i,
    input  logic        joystick_i,
    output logic [23:0] rgb_o,
    output logic        rgb_valid_o,
    output logic        frame_done_o,
    output logic        busy_o
);

    // frame_bits_p must be at least cmd_w_lp + rgb_w_lp (32).
    localparam int unsigned tx_bits_lp = 40;
    localparam int unsigned cmd_w_lp   = 8;
    localparam int unsigned rgb_w_lp   = 24;
    localparam int unsigned cnt_w_lp   = $clog2(frame_bits_p + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    state_e state_q, state_d;

    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic sd_meta_q, sd_sync_q;

    // Arming blocks a false CS fall right after reset when the pin is still low.
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;

    logic [tx_bits_lp-1:0]   tx_q, tx_d;
    logic [frame_bits_p-1:0] rx_q, rx_d;
    logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic [rgb_w_lp-1:0]     rgb_d;
    logic                    rgb_valid_d, frame_done_d, busy_d;

    logic                  cs_fall_c, cs_rise_c, sck_rise_c, sck_fall_c;
    logic                  last_bit_c;
    logic [tx_bits_lp-1:0] snap_c;

    assign cs_fall_c  = cs_prev_q & ~cs_sync_q;
    assign cs_rise_c  = ~cs_prev_q & cs_sync_q;
    assign sck_rise_c = ~sck_prev_q & sck_sync_q;
    assign sck_fall_c = sck_prev_q & ~sck_sync_q;
    assign last_bit_c = (cnt_q == cnt_w_lp'(frame_bits_p - 1));

    // Report frame: X-low, X-high, Y-low, Y-high, buttons, each sent MSB first.
    assign snap_c = {x_i[7:0], 6'b0, x_i[9:8],
                     y_i[7:0], 6'b0, y_i[9:8],
                     6'b0, trigger_i, joystick_i};

    // The MSB of the tx register drives the pin; tx is zero outside SHIFT.
    assign spi_sd_o = tx_q[tx_bits_lp-1];

    // Synchronizers, the edge-detect history and the arming flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_prev_q  <= 1'b1;
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            sd_meta_q  <= 1'b0;
            sd_sync_q  <= 1'b0;
            settle_q   <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            cs_meta_q  <= spi_cs_i;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
            sck_meta_q <= spi_sck_i;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            sd_meta_q  <= spi_sd_i;
            sd_sync_q  <= sd_meta_q;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
        end
    end

    // Arm only after the synchronizer has refilled and CS is seen high.
    always_comb begin
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd3) & cs_sync_q);
    end

    // Frame state and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            cnt_q        <= '0;
            rgb_o        <= '0;
            rgb_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            cnt_q        <= cnt_d;
            rgb_o        <= rgb_d;
            rgb_valid_o  <= rgb_valid_d;
            frame_done_o <= frame_done_d;
            busy_o       <= busy_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        cnt_d        = cnt_q;
        rgb_d        = rgb_o;
        rgb_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = '0;
                if (cs_fall_c && armed_q) begin
                    tx_d    = snap_c;
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise_c) begin
                    // A short frame is dropped silently.
                    tx_d    = '0;
                    state_d = IDLE;
                end else if (sck_rise_c) begin
                    rx_d  = {rx_q[frame_bits_p-2:0], sd_sync_q};
                    cnt_d = cnt_q + cnt_w_lp'(1);
                    if (last_bit_c) begin
                        tx_d    = '0;
                        state_d = HOLD;
                    end
                end else if (sck_fall_c) begin
                    tx_d = {tx_q[tx_bits_lp-2:0], 1'b0};
                end
            end
            HOLD: begin
                tx_d = '0;
                if (cs_rise_c) begin
                    frame_done_d = 1'b1;
                    if (rx_q[frame_bits_p-1 -: cmd_w_lp] == cmd_led_p) begin
                        rgb_d       = rx_q[frame_bits_p-1-cmd_w_lp -: rgb_w_lp];
                        rgb_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Self-checking bench for jstk_spi_responder: table of full frames plus directed corner sequences.
module tb_jstk_spi_responder;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        spi_cs_i;
    logic        spi_sck_i;
    logic        spi_sd_i;
    logic        spi_sd_o;
    logic [9:0]  x_i;
    logic [9:0]  y_i;
    logic        trigger_i;
    logic        joystick_i;
    logic [23:0] rgb_o;
    logic        rgb_valid_o;
    logic        frame_done_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int valid_cnt = 0;

    jstk_spi_responder dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .spi_cs_i    (spi_cs_i),
        .spi_sck_i   (spi_sck_i),
        .spi_sd_i    (spi_sd_i),
        .spi_sd_o    (spi_sd_o),
        .x_i         (x_i),
        .y_i         (y_i),
        .trigger_i   (trigger_i),
        .joystick_i  (joystick_i),
        .rgb_o       (rgb_o),
        .rgb_valid_o (rgb_valid_o),
        .frame_done_o(frame_done_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Count pulse cycles; a stuck pulse shows up as a count above one.
    always @(negedge clk) begin
        if (frame_done_o) done_cnt++;
        if (rgb_valid_o)  valid_cnt++;
    end

    typedef struct {
        logic [39:0] mosi;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        trig;
        logic        joy;
        logic [39:0] miso;
        logic [23:0] rgb;
        int          done;
        int          valid;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One SPI mode-0 frame, SCK half period 5 clk cycles. MOSI is left-aligned in 48 bits.
    task automatic xfer(input logic [47:0] mosi, input int nbits, input int xchg_bit,
                        input int rst_bit, output logic [47:0] miso, output logic busy_after_rst);
        miso = '0;
        busy_after_rst = 1'b1;
        @(negedge clk);
        spi_cs_i = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_sd_i = mosi[47-i];
            repeat (5) @(negedge clk);
            miso = {miso[46:0], spi_sd_o};
            spi_sck_i = 1'b1;
            if (i == xchg_bit) x_i = 10'h3FF;
            if (i == rst_bit) begin
                reset_i = 1'b1;
                @(negedge clk);
                reset_i = 1'b0;
                repeat (8) @(negedge clk);
                busy_after_rst = busy_o;
            end
            repeat (5) @(negedge clk);
            spi_sck_i = 1'b0;
        end
        repeat (5) @(negedge clk);
        spi_cs_i = 1'b1;
        spi_sd_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [9:0] x, input logic [9:0] y, input logic t, input logic j);
        x_i = x;
        y_i = y;
        trigger_i = t;
        joystick_i = j;
    endtask

    initial begin
        logic [47:0] miso;
        logic        brst;
        int          d0;
        int          v0;

        vecs[0] = '{40'h84FF008000, 10'h2A5, 10'h1C3, 1'b1, 1'b0, 40'hA502C30102, 24'hFF0080, 1, 1};
        vecs[1] = '{40'h8112345600, 10'h000, 10'h000, 1'b0, 1'b0, 40'h0000000000, 24'hFF0080, 1, 0};
        vecs[2] = '{40'h8401020300, 10'h3FF, 10'h000, 1'b0, 1'b1, 40'hFF03000001, 24'h010203, 1, 1};
        vecs[3] = '{40'h84ABCDEF00, 10'h155, 10'h2AA, 1'b1, 1'b1, 40'h5501AA0203, 24'hABCDEF, 1, 1};

        reset_i = 1'b1;
        spi_cs_i = 1'b1;
        spi_sck_i = 1'b0;
        spi_sd_i = 1'b0;
        set_inputs(10'h0, 10'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (6) @(negedge clk);

        check("reset_rgb", 48'(rgb_o), 48'h0);
        check("reset_rgb_valid", 48'(rgb_valid_o), 48'h0);
        check("reset_frame_done", 48'(frame_done_o), 48'h0);
        check("reset_busy", 48'(busy_o), 48'h0);
        check("reset_sd", 48'(spi_sd_o), 48'h0);

        // Table of complete frames.
        for (int k = 0; k < 4; k++) begin
            set_inputs(vecs[k].x, vecs[k].y, vecs[k].trig, vecs[k].joy);
            d0 = done_cnt;
            v0 = valid_cnt;
            xfer({vecs[k].mosi, 8'h00}, 40, -1, -1, miso, brst);
            check($sformatf("vec%0d_miso", k), 48'(miso[39:0]), 48'(vecs[k].miso));
            check($sformatf("vec%0d_rgb", k), 48'(rgb_o), 48'(vecs[k].rgb));
            check($sformatf("vec%0d_done", k), 48'(done_cnt - d0), 48'(vecs[k].done));
            check($sformatf("vec%0d_valid", k), 48'(valid_cnt - v0), 48'(vecs[k].valid));
            check($sformatf("vec%0d_busy", k), 48'(busy_o), 48'h0);
        end

        // First MISO bit must be on the pin three clocks after CS falls.
        set_inputs(10'h2A5, 10'h1C3, 1'b1, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        spi_cs_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("first_bit_latency", 48'(spi_sd_o), 48'h1);
        check("busy_in_frame", 48'(busy_o), 48'h1);
        @(negedge clk);
        spi_cs_i = 1'b1;
        repeat (8) @(negedge clk);
        check("zero_bit_abort_done", 48'(done_cnt - d0), 48'h0);

        // Abort after 17 bits, then a full frame.
        d0 = done_cnt;
        v0 = valid_cnt;
        xfer({40'h8412345600, 8'h00}, 17, -1, -1, miso, brst);
        check("abort_done", 48'(done_cnt - d0), 48'h0);
        check("abort_valid", 48'(valid_cnt - v0), 48'h0);
        check("abort_rgb", 48'(rgb_o), 48'hABCDEF);
        check("abort_busy", 48'(busy_o), 48'h0);
        xfer({40'h8401020300, 8'h00}, 40, -1, -1, miso, brst);
        check("after_abort_rgb", 48'(rgb_o), 48'h010203);
        check("after_abort_valid", 48'(valid_cnt - v0), 48'h1);

        // X changes mid-frame; the snapshot must be sent.
        set_inputs(10'h000, 10'h000, 1'b0, 1'b0);
        v0 = valid_cnt;
        xfer({40'h8400000000, 8'h00}, 40, 5, -1, miso, brst);
        check("xchg_miso", 48'(miso[39:0]), 48'h0);
        check("xchg_rgb", 48'(rgb_o), 48'h000000);
        check("xchg_valid", 48'(valid_cnt - v0), 48'h1);

        // 48 SCK pulses: extra bits read as zero and are ignored.
        set_inputs(10'h2A5, 10'h1C3, 1'b1, 1'b0);
        d0 = done_cnt;
        xfer({40'h8411223300, 8'hFF}, 48, -1, -1, miso, brst);
        check("long_miso", miso, {40'hA502C30102, 8'h00});
        check("long_rgb", 48'(rgb_o), 48'h112233);
        check("long_done", 48'(done_cnt - d0), 48'h1);

        // Reset at bit 20 with CS held low.
        d0 = done_cnt;
        v0 = valid_cnt;
        xfer({40'h84AABBCC00, 8'h00}, 40, -1, 20, miso, brst);
        check("rst_busy_cs_low", 48'(brst), 48'h0);
        check("rst_done", 48'(done_cnt - d0), 48'h0);
        check("rst_valid", 48'(valid_cnt - v0), 48'h0);
        check("rst_rgb", 48'(rgb_o), 48'h0);
        xfer({40'h84AABBCC00, 8'h00}, 40, -1, -1, miso, brst);
        check("post_rst_rgb", 48'(rgb_o), 48'hAABBCC);
        check("post_rst_valid", 48'(valid_cnt - v0), 48'h1);
        check("post_rst_miso", 48'(miso[39:0]), 48'hA502C30102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
